// File: rtl/als_scheduler_if.sv
// rtl/als_scheduler_if.sv - sensor driver handshake bundle for als_scheduler
interface als_scheduler_if;
  logic       als_ready;
  logic       als_fetch;
  logic [7:0] als_illum;

  modport master (input als_ready, input als_illum, output als_fetch);
  modport slave  (output als_ready, output als_illum, input als_fetch);
endinterface

// File: rtl/als_scheduler.sv
// rtl/als_scheduler.sv - periodic/on-demand ambient light sampling scheduler (option macro: ALS_SCHED_AVG_EN)
module als_scheduler #(
  parameter int PERIOD  = 1000000,
  parameter int TIMEOUT = 4096
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            enable_i,
  input  logic            req_i,
  output logic            ack_o,
  input  logic [7:0]      thr_lo_i,
  input  logic [7:0]      thr_hi_i,
  output logic [7:0]      sample_o,
  output logic [7:0]      avg_o,
  output logic            valid_o,
  output logic            dark_o,
  output logic            fault_o,
  als_scheduler_if.master als
);
  localparam int            CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, UPDATE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          pend_tick_q, pend_tick_d;
  logic          pend_host_q, pend_host_d;
  logic          cap_host_q;
  logic [TW-1:0] tmo_q;
  logic          start;
  logic [7:0]    avg_new;
  logic          als_fetch_q, valid_q, ack_q, dark_q, fault_q;
  logic [7:0]    sample_q, avg_q;

  // One transaction serves every request pending at the moment it starts
  assign start = (state_q == IDLE) && (pend_tick_q || pend_host_q) && als.als_ready;
  assign tick  = enable_i && (cnt_q == CNT_LAST);

  // Next-state for the sample period counter and the pending request flags
  always_comb begin
    cnt_d = '0;
    if (enable_i && (cnt_q != CNT_LAST)) cnt_d = cnt_q + 1'b1;
    pend_tick_d = (pend_tick_q && !start) || tick;
    pend_host_d = (pend_host_q && !start) || req_i;
  end

  // Period counter and pending flags; new sets survive a same-cycle capture
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q       <= '0;
      pend_tick_q <= 1'b0;
      pend_host_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_tick_q <= pend_tick_d;
      pend_host_q <= pend_host_d;
    end
  end

`ifdef ALS_SCHED_AVG_EN
  logic [7:0] tap0_q, tap1_q, tap2_q;
  logic       hist_vld_q;
  logic [9:0] sum;

  // Four-tap mean; an empty history behaves as if filled with the new sample
  always_comb begin
    sum = {als.als_illum, 2'b00};
    if (hist_vld_q)
      sum = {2'b00, als.als_illum} + {2'b00, tap0_q} + {2'b00, tap1_q} + {2'b00, tap2_q};
    avg_new = sum[9:2];
  end

  // Filter history shifts once per completed transaction
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tap0_q     <= '0;
      tap1_q     <= '0;
      tap2_q     <= '0;
      hist_vld_q <= 1'b0;
    end else if (state_q == UPDATE) begin
      tap0_q     <= als.als_illum;
      tap1_q     <= hist_vld_q ? tap0_q : als.als_illum;
      tap2_q     <= hist_vld_q ? tap1_q : als.als_illum;
      hist_vld_q <= 1'b1;
    end
  end
`else
  assign avg_new = als.als_illum;
`endif

  // Transaction sequencer with registered outputs and timeout supervision
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cap_host_q  <= 1'b0;
      tmo_q       <= '0;
      als_fetch_q <= 1'b0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      sample_q    <= '0;
      avg_q       <= '0;
      dark_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FETCH;
            als_fetch_q <= 1'b1;
            cap_host_q  <= pend_host_q;
            tmo_q       <= '0;
          end
        end
        FETCH: begin
          tmo_q <= tmo_q + 1'b1;
          if (!als.als_ready) begin
            state_q     <= WAIT;
            als_fetch_q <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= IDLE;
            als_fetch_q <= 1'b0;
            fault_q     <= 1'b1;
            cap_host_q  <= 1'b0;
          end
        end
        WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (als.als_ready) begin
            state_q <= UPDATE;
          end else if (tmo_q == TMO_LAST) begin
            state_q    <= IDLE;
            fault_q    <= 1'b1;
            cap_host_q <= 1'b0;
          end
        end
        UPDATE: begin
          sample_q   <= als.als_illum;
          avg_q      <= avg_new;
          valid_q    <= 1'b1;
          ack_q      <= cap_host_q;
          cap_host_q <= 1'b0;
          if (avg_new < thr_lo_i)      dark_q <= 1'b1;
          else if (avg_new > thr_hi_i) dark_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign als.als_fetch = als_fetch_q;
  assign valid_o       = valid_q;
  assign ack_o         = ack_q;
  assign sample_o      = sample_q;
  assign avg_o         = avg_q;
  assign dark_o        = dark_q;
  assign fault_o       = fault_q;
endmodule

// File: doc/als_scheduler.md
ALS_SCHEDULER -- requirements
Module: als_scheduler

Interface
REQ-001 SHALL have parameter PERIOD, default 1000000, clock cycles between periodic samples (>=16).
REQ-002 SHALL have parameter TIMEOUT, default 4096, max cycles per sensor transaction before fault.
REQ-003 Clock  input  1  system clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  periodic sampling enable.
REQ-006 req  input  1  host on-demand sample request, level-sampled per cycle.
REQ-007 ack  output  1  one-cycle pulse: host request served.
REQ-008 thr_lo, thr_hi  input  8 each  dark-detect hysteresis thresholds.
REQ-009 sample  output  8  latest raw illuminance.
REQ-010 avg  output  8  filtered illuminance.
REQ-011 valid  output  1  one-cycle pulse when sample/avg update.
REQ-012 dark  output  1  hysteresis dark flag.
REQ-013 fault  output  1  sticky transaction-timeout flag.
REQ-014 als_ready  input  1  sensor driver idle.
REQ-015 als_fetch  output  1  sensor driver start request.
REQ-016 als_illum  input  8  sensor driver result, valid once als_ready returns high.

Function
REQ-017 SHALL run a PERIOD-cycle tick counter while enable=1; counter holds at 0 while enable=0; tick at count PERIOD-1, then wraps to 0.
REQ-018 SHALL keep pend_tick and pend_host flags, set by tick and req respectively; sets are ORed, no request lost while busy.
REQ-019 States: IDLE, FETCH, WAIT, UPDATE.
REQ-020 IDLE -> FETCH when (pend_tick|pend_host) and als_ready=1; capture-and-clear both pending flags on this transition (one transaction serves both).
REQ-021 FETCH: als_fetch=1; -> WAIT on first cycle als_ready=0.
REQ-022 WAIT: als_fetch=0; -> UPDATE on first cycle als_ready=1.
REQ-023 UPDATE (1 cycle): latch sample<=als_illum, update avg and dark, pulse valid; pulse ack if captured host flag set; -> IDLE.
REQ-024 als_fetch SHALL be high only in FETCH.
REQ-025 Timeout counter reset on IDLE->FETCH; if FETCH+WAIT exceed TIMEOUT cycles: fault<=1, -> IDLE, no valid/ack, captured flags discarded.
REQ-026 fault SHALL clear only on Reset.
REQ-027 req arriving during UPDATE sets pend_host for next transaction.
REQ-028 dark set when avg<thr_lo; cleared when avg>thr_hi; otherwise held; evaluated on new avg value in UPDATE.

Reset
REQ-029 On Reset low: state IDLE, counters 0, pending flags 0, sample=0, avg=0, valid=0, ack=0, dark=0, fault=0, als_fetch=0, filter history cleared and marked empty.
REQ-030 Reset mid-transaction SHALL abandon it with no ack/valid after release.

Configuration
REQ-031 Macro ALS_SCHED_AVG_EN defined: avg = 4-tap mean, 10-bit sum of last four samples >>2 (truncate); first sample after reset preloads all four taps.
REQ-032 Macro undefined: no history registers; avg = current sample.

Verification
REQ-033 enable=1, PERIOD=16, driver model 5-cycle busy, illum=100 -> valid every 16 cycles, sample=avg=100, ack never.
REQ-034 AVG_EN, samples 100,100,100,200 -> avg 100,100,100,125; without macro -> avg 200 on fourth.
REQ-035 req pulse and tick same cycle -> exactly one als_fetch transaction, one valid, one ack.
REQ-036 thr_lo=50, thr_hi=80, avg sequence 90,40,60,85 -> dark 0,1,1,0.
REQ-037 Driver never returns ready, TIMEOUT=32 -> fault=1 after 32 cycles, state IDLE, no valid; next tick starts new transaction.
REQ-038 Reset asserted in WAIT -> all outputs zero immediately; no ack after release.
